// File: rtl/cordic_pkg.sv
// Shared types and fixed-point constants for the CORDIC vectoring engine.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ROT  = 2'd2,
        POST = 2'd3
    } state_t;

    localparam int ITER_DEF = 16;

    localparam int IN_W    = 12;
    localparam int XY_W    = 32;
    localparam int Z_W     = 64;
    localparam int IN_FRAC = 10;
    localparam int XY_FRAC = 28;
    localparam int Z_FRAC  = 54;
    localparam int IN_SH   = XY_FRAC - IN_FRAC;

    localparam logic [15:0] GAIN = 16'h9B75;

    // 180.0 in Q10.54
    localparam logic signed [Z_W-1:0] Z_180 = 64'sh2D00_0000_0000_0000;

endpackage

// File: rtl/cordic_vec_round.sv
// Rounds a Q10.54 angle to whole degrees (nearest, ties to even) and wraps
// the result into 0..359.
module cordic_vec_round
    import cordic_pkg::*;
(
    input  logic signed [Z_W-1:0] z,
    output logic        [8:0]     degree
);

    localparam logic [Z_FRAC-1:0] HALF = {1'b1, {(Z_FRAC-1){1'b0}}};

    logic signed [10:0]       int_part;
    logic        [Z_FRAC-1:0] frac;
    logic                     round_up;
    logic signed [10:0]       rounded;
    logic signed [10:0]       wrapped;

    always_comb begin
        // floor of z, sign-extended one bit so the +1 cannot overflow
        int_part = {z[Z_W-1], z[Z_W-1:Z_FRAC]};
        frac     = z[Z_FRAC-1:0];
        round_up = (frac > HALF) || ((frac == HALF) && int_part[0]);
        rounded  = int_part + {10'd0, round_up};
        wrapped  = rounded;
        if (rounded[10]) begin
            wrapped = rounded + 11'sd360;
        end else if (rounded == 11'sd360) begin
            wrapped = 11'sd0;
        end
        degree = wrapped[8:0];
    end

endmodule

// File: rtl/cordic_vec.sv
// Iterative CORDIC vectoring unit: atan2(y,x) in degrees and |(x,y)|.
// Define CORDIC_VEC_MAG_EN to build the gain-corrected magnitude output.
module cordic_vec
    import cordic_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic signed [IN_W-1:0] x_in,
    input  logic signed [IN_W-1:0] y_in,
    output logic        [8:0]      degree,
    output logic        [11:0]     mag,
    output logic                   done,
    output logic                   busy,
    output logic        [5:0]      addr,
    input  logic        [63:0]     dout
);

    state_t                 state;
    logic signed [XY_W-1:0] x_reg;
    logic signed [XY_W-1:0] y_reg;
    logic signed [Z_W-1:0]  z_reg;

    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;
    logic signed [Z_W-1:0]  atan_i;
    logic        [8:0]      deg_round;
    logic        [11:0]     mag_next;

    assign x_sh   = x_reg >>> addr;
    assign y_sh   = y_reg >>> addr;
    // Q9.55 table entry realigned to Q10.54
    assign atan_i = $signed(dout >> 1);

    cordic_vec_round u_round (
        .z      (z_reg),
        .degree (deg_round)
    );

`ifdef CORDIC_VEC_MAG_EN
    logic signed [XY_W+16:0] prod;
    logic signed [XY_W+16:0] prod_rnd;
    logic signed [XY_W+16:0] mag_full;

    // Q4.28 * Q0.16 -> Q?.44, rounded half-up to Q2.10
    assign prod     = (XY_W+17)'(x_reg) * (XY_W+17)'($signed({1'b0, GAIN}));
    assign prod_rnd = prod + ((XY_W+17)'(1) <<< 33);
    assign mag_full = prod_rnd >>> 34;

    always_comb begin
        if (mag_full < 0) begin
            mag_next = 12'h000;
        end else if (mag_full > (XY_W+17)'(4095)) begin
            mag_next = 12'hFFF;
        end else begin
            mag_next = mag_full[11:0];
        end
    end
`else
    assign mag_next = 12'h000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            x_reg  <= '0;
            y_reg  <= '0;
            z_reg  <= '0;
            addr   <= '0;
            degree <= '0;
            mag    <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_reg <= {{(XY_W-IN_W-IN_SH){x_in[IN_W-1]}}, x_in, {IN_SH{1'b0}}};
                        y_reg <= {{(XY_W-IN_W-IN_SH){y_in[IN_W-1]}}, y_in, {IN_SH{1'b0}}};
                        z_reg <= '0;
                        busy  <= 1'b1;
                        state <= PRE;
                    end
                end
                PRE: begin
                    // fold the left half-plane onto the right, pre-loading 180 degrees
                    if (x_reg[XY_W-1]) begin
                        x_reg <= -x_reg;
                        y_reg <= -y_reg;
                        z_reg <= Z_180;
                    end
                    addr  <= '0;
                    state <= ROT;
                end
                ROT: begin
                    if (!y_reg[XY_W-1]) begin
                        x_reg <= x_reg + y_sh;
                        y_reg <= y_reg - x_sh;
                        z_reg <= z_reg + atan_i;
                    end else begin
                        x_reg <= x_reg - y_sh;
                        y_reg <= y_reg + x_sh;
                        z_reg <= z_reg - atan_i;
                    end
                    if (addr == 6'(ITER-1)) begin
                        addr  <= '0;
                        state <= POST;
                    end else begin
                        addr <= addr + 6'd1;
                    end
                end
                POST: begin
                    // a zero vector never rotates, so its z is meaningless
                    if ((x_reg == '0) && (y_reg == '0)) begin
                        degree <= '0;
                    end else begin
                        degree <= deg_round;
                    end
                    mag   <= mag_next;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vec.sv
// Directed bench for cordic_vec: supplies the atan ROM, checks angles,
// magnitudes, latency, busy-start rejection and mid-run reset.
module tb_cordic_vec;

    localparam int ITER = 16;
    localparam int LAT  = ITER + 2;
    localparam real PI  = 3.14159265358979323846;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [11:0] x_in  = '0;
    logic [11:0] y_in  = '0;
    logic [8:0]  degree;
    logic [11:0] mag;
    logic        done;
    logic        busy;
    logic [5:0]  addr;
    logic [63:0] dout;

    logic [63:0] rom [64];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dout = rom[addr];

    cordic_vec #(.ITER(ITER)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x_in   (x_in),
        .y_in   (y_in),
        .degree (degree),
        .mag    (mag),
        .done   (done),
        .busy   (busy),
        .addr   (addr),
        .dout   (dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] got, input int lo, input int hi);
        checks++;
        assert (((got >= 32'(lo)) && (got <= 32'(hi))) === 1'b1) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic chk_mag(input string tag, input int lo, input int hi);
`ifdef CORDIC_VEC_MAG_EN
        chk_rng(tag, 32'(mag), lo, hi);
`else
        chk(tag, 32'(mag), 32'd0);
`endif
    endtask

    // One full operation; inputs are scrambled after the sampling edge so a
    // design that re-reads them would produce the wrong answer.
    task automatic run_op(input string tag, input logic [11:0] xv, input logic [11:0] yv,
                          input int exp_deg, input int mag_lo, input int mag_hi);
        int lat;
        lat = -1;
        @(negedge clk);
        x_in  = xv;
        y_in  = yv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x_in  = ~xv;
        y_in  = ~yv;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(LAT));
        chk({tag, " degree"}, 32'(degree), 32'(exp_deg));
        chk_mag({tag, " mag"}, mag_lo, mag_hi);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, " addr_at_done"}, 32'(addr), 32'd0);
        $display("op %s x=%h y=%h degree=%0d mag=%h latency=%0d", tag, xv, yv, degree, mag, lat);
    endtask

    initial begin
        real p;
        int  nd;
        int  lat;

        p = 1.0;
        for (int i = 0; i < 64; i++) begin
            rom[i] = 64'(longint'($atan(p) * (180.0 / PI) * (2.0 ** 55)));
            p = p * 0.5;
        end

        #2 rst_n = 1'b0;
        #1;
        chk("reset degree", 32'(degree), 32'd0);
        chk("reset mag",    32'(mag),    32'd0);
        chk("reset done",   32'(done),   32'd0);
        chk("reset busy",   32'(busy),   32'd0);
        chk("reset addr",   32'(addr),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("op reset degree=%0d mag=%h busy=%0d", degree, mag, busy);

        run_op("deg0",    12'h400, 12'h000,   0, 1022, 1026);
        run_op("deg90",   12'h000, 12'h400,  90, 1022, 1026);
        run_op("deg180",  12'hC00, 12'h000, 180, 1022, 1026);
        run_op("deg270",  12'h000, 12'hC00, 270, 1022, 1026);
        run_op("deg45",   12'h2D4, 12'h2D4,  45, 1021, 1027);
        run_op("deg315",  12'h2D4, 12'hD2C, 315, 1021, 1027);
        run_op("deg135",  12'hC00, 12'h400, 135, 1445, 1451);
        run_op("deg225",  12'h800, 12'h800, 225, 2893, 2899);
        run_op("near180", 12'hC00, 12'hFFF, 180, 1022, 1026);
        run_op("wrap360", 12'h400, 12'hFF9,   0, 1022, 1026);
        run_op("deg90b",  12'h000, 12'h400,  90, 1022, 1026);
        run_op("zero",    12'h000, 12'h000,   0,    0,    0);
        run_op("deg135b", 12'hC00, 12'h400, 135, 1445, 1451);

        // results hold while idle
        nd = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) nd++;
        end
        chk("hold degree", 32'(degree), 32'd135);
        chk("hold no done", 32'(nd), 32'd0);
        $display("op hold degree=%0d mag=%h", degree, mag);

        // second start during ROT must be ignored
        @(negedge clk);
        x_in  = 12'h400;
        y_in  = 12'h000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nd  = 0;
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) begin
                chk("midrot addr", 32'(addr), 32'd4);
                x_in  = 12'h000;
                y_in  = 12'h400;
                start = 1'b1;
            end
            if (n == 6) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                if (lat < 0) lat = n;
            end
        end
        chk("restart latency", 32'(lat), 32'(LAT));
        chk("restart done count", 32'(nd), 32'd1);
        chk("restart degree", 32'(degree), 32'd0);
        chk_mag("restart mag", 1022, 1026);
        $display("op restart degree=%0d mag=%h dones=%0d latency=%0d", degree, mag, nd, lat);

        // asynchronous reset during the fifth ROT cycle
        run_op("pre_rst", 12'h000, 12'h400, 90, 1022, 1026);
        @(negedge clk);
        x_in  = 12'hC00;
        y_in  = 12'h400;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 5; n++) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst degree", 32'(degree), 32'd0);
        chk("midrst mag",    32'(mag),    32'd0);
        chk("midrst busy",   32'(busy),   32'd0);
        chk("midrst addr",   32'(addr),   32'd0);
        chk("midrst done",   32'(done),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) nd++;
        end
        chk("midrst no done", 32'(nd), 32'd0);
        $display("op midrst degree=%0d mag=%h dones=%0d", degree, mag, nd);
        run_op("post_rst", 12'hC00, 12'h400, 135, 1445, 1451);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
